smg_page_sel: RTL and testbench

- Upstream data-source stage for the 7-segment scan driver.
- Chooses which 16-bit word the display shows: motor page or sensor page.
- Takes snapshots of that word at a fixed refresh rate so digits do not flicker.
- Rotates pages automatically on a timer, or manually from a debounced push-button.

---
 rtl/smg_pkg.sv | 14 +
 rtl/smg_btn_debounce.sv | 53 +++++
 rtl/smg_page_sel.sv | 91 +++++++++
 tb/tb_smg_page_sel.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared constants and page encoding for the 7-segment page-select data path.
package smg_pkg;

    typedef enum logic {
        PG_MOTOR  = 1'b0,
        PG_SENSOR = 1'b1
    } page_e;

    // Tick defaults for a 100 MHz clock.
    localparam int unsigned PAGE_TICKS_DEF     = 200_000_000;
    localparam int unsigned REFRESH_TICKS_DEF  = 10_000_000;
    localparam int unsigned DEBOUNCE_TICKS_DEF = 1_000_000;

endpackage

// File: rtl/smg_btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, stability debounce, and a
// single-cycle pulse on each accepted press.
module smg_btn_debounce
    import smg_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_TICKS);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_dly_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter measures how long the synchronised level has disagreed
    // with the accepted level; any agreement restarts the measurement.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
        end
    end

    assign press_pulse = deb_q & ~deb_dly_q;

endmodule

// File: rtl/smg_page_sel.sv
// Selects motor or sensor word for the scan driver, rotating pages on a timer
// or button press, and snapshots the word at a fixed refresh rate.
module smg_page_sel
    import smg_pkg::*;
#(
    parameter int unsigned PAGE_TICKS     = PAGE_TICKS_DEF,
    parameter int unsigned REFRESH_TICKS  = REFRESH_TICKS_DEF,
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic [15:0] motor_data,
    input  logic [15:0] sensor_data,
    input  logic        btn_next,
    input  logic        auto_en,
    output logic [15:0] data,
    output logic        page,
    output logic        update
);

    localparam int unsigned PW = $clog2(PAGE_TICKS);
    localparam int unsigned RW = $clog2(REFRESH_TICKS);

    logic          next_req;
    logic          timer_term, refresh_term, page_tog;
    logic [PW-1:0] timer_q, timer_d;
    logic [RW-1:0] refresh_q, refresh_d;
    page_e         page_q, page_d;
    logic          load_pend_q, load_pend_d;
    logic [15:0]   data_q, data_d;
    logic          update_q, update_d;

    smg_btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_btn (
        .clk_100MHz  (clk_100MHz),
        .rst         (rst),
        .btn_raw     (btn_next),
        .press_pulse (next_req)
    );

    always_comb begin
        timer_term   = auto_en && (timer_q == PW'(PAGE_TICKS - 1));
        page_tog     = next_req || timer_term;
        refresh_term = (refresh_q == RW'(REFRESH_TICKS - 1));

        timer_d = timer_q + PW'(1);
        if (next_req || !auto_en || timer_term) begin
            timer_d = '0;
        end

        page_d = page_q;
        if (page_tog) begin
            page_d = (page_q == PG_MOTOR) ? PG_SENSOR : PG_MOTOR;
        end
        load_pend_d = page_tog;

        // A page-change load and a refresh terminal count merge into one load.
        refresh_d = refresh_q + RW'(1);
        data_d    = data_q;
        update_d  = 1'b0;
        if (load_pend_q || refresh_term) begin
            refresh_d = '0;
            data_d    = (page_q == PG_SENSOR) ? sensor_data : motor_data;
            update_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            timer_q     <= '0;
            refresh_q   <= '0;
            page_q      <= PG_MOTOR;
            load_pend_q <= 1'b0;
            data_q      <= '0;
            update_q    <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            refresh_q   <= refresh_d;
            page_q      <= page_d;
            load_pend_q <= load_pend_d;
            data_q      <= data_d;
            update_q    <= update_d;
        end
    end

    assign data   = data_q;
    assign page   = page_q;
    assign update = update_q;

endmodule

// File: tb/tb_smg_page_sel.sv
// Randomised and directed bench for smg_page_sel against a cycle-level
// behavioural model built from history windows and modulo counters.
module tb_smg_page_sel;

    localparam int PT = 20;
    localparam int RT = 8;
    localparam int DT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] motor_data = '0;
    logic [15:0] sensor_data = '0;
    logic        btn_next = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] data;
    logic        page;
    logic        update;

    smg_page_sel #(
        .PAGE_TICKS     (PT),
        .REFRESH_TICKS  (RT),
        .DEBOUNCE_TICKS (DT)
    ) dut (
        .clk_100MHz  (clk),
        .rst         (rst),
        .motor_data  (motor_data),
        .sensor_data (sensor_data),
        .btn_next    (btn_next),
        .auto_en     (auto_en),
        .data        (data),
        .page        (page),
        .update      (update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    logic        m_raw [2];      // raw button at the previous two edges
    logic        m_level;        // accepted button level
    logic        m_level_prev;   // accepted level one cycle earlier
    int          m_run;          // cycles the synced level has disagreed
    int          m_timer;
    int          m_ref;
    logic        m_page;
    logic        m_load;
    logic [15:0] m_data;
    logic        m_upd;

    int   tick_no = 0;
    int   toggles = 0;
    int   last_toggle = -1;
    int   upd_cnt = 0;
    logic last_page = 1'b0;

    task automatic model_step();
        logic s, press, tog;
        if (rst) begin
            m_raw[0] = 0; m_raw[1] = 0;
            m_level = 0; m_level_prev = 0; m_run = 0;
            m_timer = 0; m_ref = 0; m_page = 0; m_load = 0;
            m_data = '0; m_upd = 0;
        end else begin
            s     = m_raw[1];
            press = m_level && !m_level_prev;
            tog   = press || (auto_en && m_timer == PT - 1);

            if (m_load || m_ref == RT - 1) begin
                m_data = m_page ? sensor_data : motor_data;
                m_upd  = 1;
                m_ref  = 0;
            end else begin
                m_upd = 0;
                m_ref = m_ref + 1;
            end

            m_timer = (press || !auto_en) ? 0 : (m_timer + 1) % PT;
            m_page  = m_page ^ tog;
            m_load  = tog;

            m_level_prev = m_level;
            m_run = (s != m_level) ? m_run + 1 : 0;
            if (m_run == DT) begin
                m_level = s;
                m_run   = 0;
            end
            m_raw[1] = m_raw[0];
            m_raw[0] = btn_next;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("data", data, m_data);
        chk("page", {15'd0, page}, {15'd0, m_page});
        chk("update", {15'd0, update}, {15'd0, m_upd});
        if (page !== last_page) begin
            toggles++;
            last_toggle = tick_no;
        end
        if (update === 1'b1) upd_cnt++;
        last_page = page;
        tick_no++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int t0, tg0, u0, hold, lvl;

        // 1. reset and plain refresh
        motor_data  = 16'h1234;
        sensor_data = 16'hABCD;
        rst = 1'b1;
        ticks(3);
        chk("rst_data", data, 16'h0000);
        chk("rst_page", {15'd0, page}, 16'd0);
        chk("rst_update", {15'd0, update}, 16'd0);
        rst = 1'b0;
        u0 = upd_cnt;
        ticks(24);
        chk("t1_upd_count", 16'(upd_cnt - u0), 16'd3);
        chk("t1_data", data, 16'h1234);
        chk("t1_page", {15'd0, page}, 16'd0);

        // 2. auto rotation
        auto_en = 1'b1;
        ticks(20);
        chk("t2_page_20", {15'd0, page}, 16'd1);
        tick();
        chk("t2_data_21", data, 16'hABCD);
        chk("t2_upd_21", {15'd0, update}, 16'd1);
        ticks(19);
        chk("t2_page_40", {15'd0, page}, 16'd0);
        tick();
        chk("t2_data_41", data, 16'h1234);

        // 3. bounce rejection, press latency, hold
        auto_en = 1'b0;
        ticks(4);
        tg0 = toggles;
        btn_next = 1'b1;
        ticks(2);
        btn_next = 1'b0;
        ticks(20);
        chk("t3_bounce", 16'(toggles - tg0), 16'd0);
        tg0 = toggles;
        t0  = tick_no;
        btn_next = 1'b1;
        ticks(110);
        chk("t3_hold_toggles", 16'(toggles - tg0), 16'd1);
        chk("t3_latency", 16'(last_toggle - t0), 16'd6);
        btn_next = 1'b0;
        ticks(20);

        // 4. press coinciding with timer terminal count
        auto_en = 1'b1;
        for (int i = 0; i < 3 * PT && m_timer != PT - 7; i++) tick();
        chk("t4_align", 16'(m_timer), 16'(PT - 7));
        tg0 = toggles;
        t0  = tick_no;
        btn_next = 1'b1;
        ticks(10);
        chk("t4_one_toggle", 16'(toggles - tg0), 16'd1);
        chk("t4_toggle_at", 16'(last_toggle - t0), 16'd6);
        btn_next = 1'b0;
        ticks(30);

        // 5. load_pend coinciding with refresh terminal count
        auto_en = 1'b0;
        ticks(10);
        for (int i = 0; i < 3 * RT && m_ref != (2 * RT - 8) % RT; i++) tick();
        chk("t5_align", 16'(m_ref), 16'((2 * RT - 8) % RT));
        u0 = upd_cnt;
        t0 = tick_no;
        btn_next = 1'b1;
        ticks(15);
        chk("t5_upd_count", 16'(upd_cnt - u0), 16'd1);
        chk("t5_data", data, page ? 16'hABCD : 16'h1234);
        btn_next = 1'b0;
        ticks(20);

        // 6. reset during debounce with sensor page shown
        if (!m_page) begin
            btn_next = 1'b1;
            ticks(10);
            btn_next = 1'b0;
            ticks(12);
        end
        ticks(RT);
        chk("t6_pre_page", {15'd0, page}, 16'd1);
        chk("t6_pre_data", data, 16'hABCD);
        btn_next = 1'b1;
        ticks(3);
        rst = 1'b1;
        btn_next = 1'b0;
        tick();
        chk("t6_page", {15'd0, page}, 16'd0);
        chk("t6_data", data, 16'h0000);
        chk("t6_update", {15'd0, update}, 16'd0);
        rst = 1'b0;
        tg0 = toggles;
        ticks(30);
        chk("t6_press_lost", 16'(toggles - tg0), 16'd0);

        // Random phase
        hold = 0;
        lvl  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                lvl  = $urandom_range(0, 1);
                hold = (lvl != 0) ? $urandom_range(1, 12) : $urandom_range(1, 30);
            end
            hold--;
            btn_next = lvl[0];
            if ($urandom_range(0, 99) < 3) auto_en = ~auto_en;
            if ($urandom_range(0, 1) == 0) motor_data = 16'($urandom);
            if ($urandom_range(0, 1) == 0) sensor_data = 16'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
